// File: rtl/cart_map_arbiter.sv
// N-channel cartridge mapper arbiter: picks one mapper's ROM/BSRAM/CPU signals from a one-hot
// request, with select debounce, a write-safe switch-over guard and a sticky conflict flag.
module cart_map_arbiter #(
    parameter int NCH      = 5,
    parameter int ROM_AW   = 24,
    parameter int BSRAM_AW = 20,
    parameter int DEBOUNCE = 2,
    parameter int GUARD    = 4
) (
    input  logic                    mclk,
    input  logic                    rst_n,
    input  logic [NCH-2:0]          map_active,
    input  logic [NCH*8-1:0]        ch_do,
    input  logic [NCH-1:0]          ch_irq_n,
    input  logic [NCH*ROM_AW-1:0]   ch_rom_addr,
    input  logic [NCH-1:0]          ch_rom_ce_n,
    input  logic [NCH-1:0]          ch_rom_oe_n,
    input  logic [NCH-1:0]          ch_rom_word,
    input  logic [NCH*BSRAM_AW-1:0] ch_bsram_addr,
    input  logic [NCH*8-1:0]        ch_bsram_d,
    input  logic [NCH-1:0]          ch_bsram_ce_n,
    input  logic [NCH-1:0]          ch_bsram_oe_n,
    input  logic [NCH-1:0]          ch_bsram_we_n,
    output logic [7:0]              di,
    output logic                    irq_n,
    output logic [ROM_AW-1:0]       rom_addr,
    output logic                    rom_ce_n,
    output logic                    rom_oe_n,
    output logic                    rom_word,
    output logic [BSRAM_AW-1:0]     bsram_addr,
    output logic [7:0]              bsram_d,
    output logic                    bsram_ce_n,
    output logic                    bsram_oe_n,
    output logic                    bsram_we_n,
    output logic [$clog2(NCH)-1:0]  sel,
    output logic                    switching,
    output logic                    conflict
);

    localparam int SW = $clog2(NCH);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic {ST_RUN = 1'b0, ST_GUARD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   tgt_q, tgt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [SW-1:0]   cand_q;
    logic [DW-1:0]   stab_q, stab_d;
    logic            conflict_q;

    logic [SW-1:0]   cand;
    logic            multi;
    int              nset;
    logic            acc_vld;

    logic [7:0]          m_do;
    logic                m_irq_n;
    logic [ROM_AW-1:0]   m_rom_addr;
    logic                m_rom_ce_n, m_rom_oe_n, m_rom_word;
    logic [BSRAM_AW-1:0] m_bsram_addr;
    logic [7:0]          m_bsram_d;
    logic                m_bsram_ce_n, m_bsram_oe_n, m_bsram_we_n;

    always_comb begin
        nset  = 0;
        cand  = '0;
        for (int k = 0; k < NCH-1; k++) begin
            if (map_active[k]) begin
                nset = nset + 1;
                cand = SW'(k + 1);
            end
        end
        multi = (nset > 1);
        if (multi) cand = '0;
    end

    // Stability count includes the current cycle, so a request held DEBOUNCE cycles is accepted
    // on the last of them and acc is simply the live candidate.
    always_comb begin
        if (cand != cand_q)
            stab_d = DW'(1);
        else if (stab_q >= DW'(DEBOUNCE))
            stab_d = stab_q;
        else
            stab_d = stab_q + DW'(1);
        acc_vld = (stab_d >= DW'(DEBOUNCE));
    end

    always_comb begin
        m_do         = '0;
        m_irq_n      = 1'b1;
        m_rom_addr   = '0;
        m_rom_ce_n   = 1'b1;
        m_rom_oe_n   = 1'b1;
        m_rom_word   = 1'b0;
        m_bsram_addr = '0;
        m_bsram_d    = '0;
        m_bsram_ce_n = 1'b1;
        m_bsram_oe_n = 1'b1;
        m_bsram_we_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (sel_q == SW'(c)) begin
                m_do         = ch_do[c*8 +: 8];
                m_irq_n      = ch_irq_n[c];
                m_rom_addr   = ch_rom_addr[c*ROM_AW +: ROM_AW];
                m_rom_ce_n   = ch_rom_ce_n[c];
                m_rom_oe_n   = ch_rom_oe_n[c];
                m_rom_word   = ch_rom_word[c];
                m_bsram_addr = ch_bsram_addr[c*BSRAM_AW +: BSRAM_AW];
                m_bsram_d    = ch_bsram_d[c*8 +: 8];
                m_bsram_ce_n = ch_bsram_ce_n[c];
                m_bsram_oe_n = ch_bsram_oe_n[c];
                m_bsram_we_n = ch_bsram_we_n[c];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            ST_RUN: begin
                // An in-flight BSRAM write on the current channel holds off the switch.
                if (acc_vld && cand != sel_q && m_bsram_we_n) begin
                    state_d = ST_GUARD;
                    tgt_d   = cand;
                    gcnt_d  = GW'(GUARD - 1);
                end
            end
            ST_GUARD: begin
                // A request that moved back or elsewhere outranks finishing the stale switch.
                if (acc_vld && cand == sel_q) begin
                    state_d = ST_RUN;
                end else if (acc_vld && cand != tgt_q) begin
                    tgt_d  = cand;
                    gcnt_d = GW'(GUARD - 1);
                end else if (gcnt_q == '0) begin
                    sel_d   = tgt_q;
                    state_d = ST_RUN;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            sel_q      <= '0;
            tgt_q      <= '0;
            gcnt_q     <= '0;
            cand_q     <= '0;
            stab_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tgt_q      <= tgt_d;
            gcnt_q     <= gcnt_d;
            cand_q     <= cand;
            stab_q     <= stab_d;
            conflict_q <= conflict_q | multi;
        end
    end

    always_comb begin
        di         = m_do;
        irq_n      = m_irq_n;
        rom_addr   = m_rom_addr;
        rom_ce_n   = m_rom_ce_n;
        rom_oe_n   = m_rom_oe_n;
        rom_word   = m_rom_word;
        bsram_addr = m_bsram_addr;
        bsram_d    = m_bsram_d;
        bsram_ce_n = m_bsram_ce_n;
        bsram_oe_n = m_bsram_oe_n;
        bsram_we_n = m_bsram_we_n;
        if (state_q == ST_GUARD) begin
            di         = 8'h00;
            irq_n      = 1'b1;
            rom_ce_n   = 1'b1;
            rom_oe_n   = 1'b1;
            rom_word   = 1'b0;
            bsram_ce_n = 1'b1;
            bsram_oe_n = 1'b1;
            bsram_we_n = 1'b1;
        end
    end

    assign sel       = sel_q;
    assign switching = (state_q == ST_GUARD);
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_cart_map_arbiter.sv
// Bench for cart_map_arbiter: hand-derived cycle table for the switch/abort/defer/conflict
// corners, then long random traffic against a request-history reference model.
module tb_cart_map_arbiter;

    localparam int NCH      = 5;
    localparam int ROM_AW   = 24;
    localparam int BSRAM_AW = 20;
    localparam int DEBOUNCE = 2;
    localparam int GUARD    = 4;
    localparam int BUS_W    = 67;

    logic                    mclk = 1'b0;
    logic                    rst_n;
    logic [NCH-2:0]          map_active;
    logic [NCH*8-1:0]        ch_do;
    logic [NCH-1:0]          ch_irq_n;
    logic [NCH*ROM_AW-1:0]   ch_rom_addr;
    logic [NCH-1:0]          ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
    logic [NCH*BSRAM_AW-1:0] ch_bsram_addr;
    logic [NCH*8-1:0]        ch_bsram_d;
    logic [NCH-1:0]          ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
    logic [7:0]              di;
    logic                    irq_n;
    logic [ROM_AW-1:0]       rom_addr;
    logic                    rom_ce_n, rom_oe_n, rom_word;
    logic [BSRAM_AW-1:0]     bsram_addr;
    logic [7:0]              bsram_d;
    logic                    bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [2:0]              sel;
    logic                    switching, conflict;

    cart_map_arbiter #(
        .NCH(NCH), .ROM_AW(ROM_AW), .BSRAM_AW(BSRAM_AW), .DEBOUNCE(DEBOUNCE), .GUARD(GUARD)
    ) dut (
        .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
        .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
        .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
        .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d), .ch_bsram_ce_n(ch_bsram_ce_n),
        .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
        .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
        .sel(sel), .switching(switching), .conflict(conflict)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [3:0] ma;
        logic       we0;
        logic [2:0] esel;
        logic       esw;
        logic       econf;
    } vec_t;

    vec_t tab[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: granted channel, guard flag with remaining guard cycles, pending target,
    // sticky conflict and the recent history of decoded requests.
    int m_sel, m_tgt, m_left;
    bit m_guard, m_conf;
    int hist[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_sel = 0; m_tgt = 0; m_left = 0; m_guard = 0; m_conf = 0;
    endtask

    function automatic logic [BUS_W-1:0] exp_bus();
        int i = m_sel;
        if (m_guard)
            return {8'h00, 1'b1, ch_rom_addr[i*ROM_AW +: ROM_AW], 1'b1, 1'b1, 1'b0,
                    ch_bsram_addr[i*BSRAM_AW +: BSRAM_AW], ch_bsram_d[i*8 +: 8], 3'b111};
        return {ch_do[i*8 +: 8], ch_irq_n[i], ch_rom_addr[i*ROM_AW +: ROM_AW], ch_rom_ce_n[i],
                ch_rom_oe_n[i], ch_rom_word[i], ch_bsram_addr[i*BSRAM_AW +: BSRAM_AW],
                ch_bsram_d[i*8 +: 8], ch_bsram_ce_n[i], ch_bsram_oe_n[i], ch_bsram_we_n[i]};
    endfunction

    task automatic check_model(input string tag);
        logic [BUS_W-1:0] got;
        got = {di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
               bsram_ce_n, bsram_oe_n, bsram_we_n};
        chk({tag, ".sel"}, 128'(sel), 128'(m_sel));
        chk({tag, ".switching"}, 128'(switching), 128'(m_guard));
        chk({tag, ".conflict"}, 128'(conflict), 128'(m_conf));
        chk({tag, ".bus"}, 128'(got), 128'(exp_bus()));
    endtask

    // Applies one clock edge's worth of the arbitration rules to the model.
    task automatic model_edge();
        int n = 0;
        int c = 0;
        bit stable;
        for (int k = 0; k < NCH-1; k++)
            if (map_active[k]) begin n++; c = k + 1; end
        if (n > 1) begin c = 0; m_conf = 1; end
        hist.push_back(c);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        stable = (hist.size() == DEBOUNCE);
        foreach (hist[j]) if (hist[j] != c) stable = 0;
        if (!m_guard) begin
            if (stable && c != m_sel && ch_bsram_we_n[m_sel]) begin
                m_guard = 1; m_tgt = c; m_left = GUARD;
            end
        end else if (stable && c == m_sel) begin
            m_guard = 0;
        end else if (stable && c != m_tgt) begin
            m_tgt = c; m_left = GUARD;
        end else if (m_left == 1) begin
            m_sel = m_tgt; m_guard = 0;
        end else begin
            m_left--;
        end
    endtask

    task automatic rand_ch(input bit directed, input logic we0);
        for (int c = 0; c < NCH; c++) begin
            ch_do[c*8 +: 8]                   = 8'($urandom);
            ch_irq_n[c]                       = 1'($urandom);
            ch_rom_addr[c*ROM_AW +: ROM_AW]   = ROM_AW'($urandom);
            ch_rom_ce_n[c]                    = 1'($urandom);
            ch_rom_oe_n[c]                    = 1'($urandom);
            ch_rom_word[c]                    = 1'($urandom);
            ch_bsram_addr[c*BSRAM_AW +: BSRAM_AW] = BSRAM_AW'($urandom);
            ch_bsram_d[c*8 +: 8]              = 8'($urandom);
            ch_bsram_ce_n[c]                  = 1'($urandom);
            ch_bsram_oe_n[c]                  = 1'($urandom);
            ch_bsram_we_n[c]                  = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        if (directed) ch_bsram_we_n[0] = we0;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input logic [3:0] ma, input bit directed, input logic we0, input string tag);
        map_active = ma;
        rand_ch(directed, we0);
        @(negedge mclk);
        check_model(tag);
        @(posedge mclk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [3:0] ma;
        int hold;
        vec_t v;

        // ma, we0, expected sel, switching, conflict for each cycle after reset release
        tab.push_back('{4'h0, 1'b1, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h4, 1'b1, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) tab.push_back('{4'h4, 1'b1, 3'd0, 1'b1, 1'b0});
        tab.push_back('{4'h4, 1'b1, 3'd3, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h0, 1'b1, 3'd3, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) tab.push_back('{4'h0, 1'b1, 3'd3, 1'b1, 1'b0});
        tab.push_back('{4'h0, 1'b1, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h4, 1'b1, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h0, 1'b1, 3'd0, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h0, 1'b1, 3'd0, 1'b0, 1'b0});
        tab.push_back('{4'h6, 1'b1, 3'd0, 1'b0, 1'b0});
        tab.push_back('{4'h6, 1'b1, 3'd0, 1'b0, 1'b1});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h0, 1'b1, 3'd0, 1'b0, 1'b1});
        tab.push_back('{4'h2, 1'b1, 3'd0, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) tab.push_back('{4'h2, 1'b0, 3'd0, 1'b0, 1'b1});
        tab.push_back('{4'h2, 1'b1, 3'd0, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) tab.push_back('{4'h2, 1'b1, 3'd0, 1'b1, 1'b1});
        tab.push_back('{4'h2, 1'b1, 3'd2, 1'b0, 1'b1});
        tab.push_back('{4'h1, 1'b1, 3'd2, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) tab.push_back('{4'h2, 1'b1, 3'd2, 1'b0, 1'b1});
        for (int i = 0; i < 2; i++) tab.push_back('{4'h8, 1'b1, 3'd2, 1'b0, 1'b1});
        tab.push_back('{4'h8, 1'b1, 3'd2, 1'b1, 1'b1});

        rst_n = 1'b0;
        map_active = '0;
        rand_ch(1'b1, 1'b1);
        model_reset();
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check_model("reset");
        @(posedge mclk);
        #1 rst_n = 1'b1;

        foreach (tab[i]) begin
            v = tab[i];
            map_active = v.ma;
            rand_ch(1'b1, v.we0);
            @(negedge mclk);
            check_model($sformatf("tab%0d", i));
            chk($sformatf("tab%0d.sel", i), 128'(sel), 128'(v.esel));
            chk($sformatf("tab%0d.switching", i), 128'(switching), 128'(v.esw));
            chk($sformatf("tab%0d.conflict", i), 128'(conflict), 128'(v.econf));
            if (v.we0 == 1'b0)
                chk($sformatf("tab%0d.write_kept", i), 128'(bsram_we_n), 128'(1'b0));
            @(posedge mclk);
            model_edge();
            #1;
        end

        // Still mid-guard toward channel 4: asynchronous reset must act without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.sel", 128'(sel), 128'(0));
        chk("async_rst.switching", 128'(switching), 128'(0));
        chk("async_rst.conflict", 128'(conflict), 128'(0));
        check_model("async_rst");
        @(posedge mclk);
        #1 rst_n = 1'b1;

        hold = 0;
        ma = '0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    ma = 4'h0;
                    9:       ma = 4'($urandom);
                    default: ma = 4'(1 << $urandom_range(0, 3));
                endcase
                hold = $urandom_range(1, 12);
            end
            hold--;
            cycle(ma, 1'b0, 1'b1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
